// File: rtl/thread_dispatcher_pkg.sv
// Shared types and sizing for the thread dispatcher and its round-robin allocator.
// Thread ids are 3 bits; the value NUM_Threads marks an idle ALU slot.
package thread_dispatcher_pkg;
    localparam int NUM_Threads   = 4;
    localparam int NUM_ALUs      = 4;
    localparam int REFILL_CYCLES = 2;
    localparam int THREAD_IDLE   = NUM_Threads;
    localparam int CNT_W         = $clog2(REFILL_CYCLES + 1);

    typedef logic [2:0]       thread_id_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {STARTUP, RUN, FROZEN} disp_state_t;

    localparam thread_id_t THREAD_IDLE_ID = thread_id_t'(THREAD_IDLE);
    localparam cnt_t       REFILL_CNT     = cnt_t'(REFILL_CYCLES);

    // Compare-based wrap so NUM_Threads need not be a power of two.
    function automatic int wrap_inc(input int t);
        return (t + 1 >= NUM_Threads) ? 0 : t + 1;
    endfunction
endpackage

// File: rtl/thread_dispatcher_rr_alloc.sv
// Combinational round-robin scan: eligible threads from i_rr_ptr onward take the lowest free ALUs.
// Zero latency; an eligible thread left without a free ALU simply waits for a later cycle.
module rr_alloc
    import thread_dispatcher_pkg::*;
(
    input  logic [NUM_Threads-1:0]    i_eligible,
    input  logic [NUM_ALUs-1:0]       i_alu_free,
    input  thread_id_t                i_rr_ptr,
    output thread_id_t [NUM_ALUs-1:0] o_assign,
    output thread_id_t                o_rr_next
);
    always_comb begin
        logic [NUM_ALUs-1:0] w_free;
        logic                w_placed;
        logic                w_elig;
        int                  w_tid;
        w_free    = i_alu_free;
        o_assign  = {NUM_ALUs{THREAD_IDLE_ID}};
        o_rr_next = i_rr_ptr;
        w_placed  = 1'b0;
        w_elig    = 1'b0;
        w_tid     = 0;
        for (int k = 0; k < NUM_Threads; k++) begin
            w_tid = int'(i_rr_ptr) + k;
            if (w_tid >= NUM_Threads) begin
                w_tid = w_tid - NUM_Threads;
            end
            w_elig = 1'b0;
            for (int t = 0; t < NUM_Threads; t++) begin
                if (t == w_tid) begin
                    w_elig = i_eligible[t];
                end
            end
            w_placed = 1'b0;
            for (int a = 0; a < NUM_ALUs; a++) begin
                if (w_elig && !w_placed && w_free[a]) begin
                    o_assign[a] = thread_id_t'(w_tid);
                    w_free[a]   = 1'b0;
                    w_placed    = 1'b1;
                end
            end
            // Pointer follows the last thread that actually won an ALU.
            if (w_placed) begin
                o_rr_next = thread_id_t'(wrap_inc(w_tid));
            end
        end
    end
endmodule

// File: rtl/thread_dispatcher.sv
// Per-cycle dispatcher sharing NUM_ALUs execute units among NUM_Threads threads in round-robin order.
// One registered stage; busy ALUs, freeze, startup and jump refill windows just leave slots idle.
module thread_dispatcher
    import thread_dispatcher_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_Threads-1:0]    thread_ready,
    input  logic [NUM_Threads-1:0]    jump_en,
    input  logic [NUM_ALUs-1:0]       alu_busy,
    input  logic                      freeze,
    output thread_id_t [NUM_ALUs-1:0] dispatch_threads,
    output logic [NUM_Threads-1:0]    grant_vec,
    output thread_id_t                rr_ptr
);
    disp_state_t               r_state;
    disp_state_t               w_state_next;
    logic                      w_arb_en;
    cnt_t                      r_start_cnt;
    cnt_t [NUM_Threads-1:0]    r_blackout;
    logic [NUM_Threads-1:0]    w_eligible;
    logic [NUM_Threads-1:0]    w_grant;
    logic [NUM_Threads-1:0]    r_grant;
    thread_id_t [NUM_ALUs-1:0] w_assign;
    thread_id_t [NUM_ALUs-1:0] r_disp;
    thread_id_t                w_rr_next;
    thread_id_t                r_rr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= STARTUP;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_arb_en     = 1'b0;
        unique case (r_state)
            STARTUP: if (r_start_cnt <= cnt_t'(1)) w_state_next = RUN;
            RUN: begin
                w_arb_en = !freeze;
                if (freeze) w_state_next = FROZEN;
            end
            FROZEN: begin
                w_arb_en = !freeze;
                if (!freeze) w_state_next = RUN;
            end
            default: w_state_next = STARTUP;
        endcase
    end

    // Mirrors ifetch's post-reset refill window; freeze does not stretch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_cnt <= REFILL_CNT;
        end else if (r_state == STARTUP && r_start_cnt != '0) begin
            r_start_cnt <= r_start_cnt - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blackout <= '0;
        end else begin
            for (int t = 0; t < NUM_Threads; t++) begin
                if (jump_en[t])                r_blackout[t] <= REFILL_CNT;
                else if (r_blackout[t] != '0)  r_blackout[t] <= r_blackout[t] - cnt_t'(1);
            end
        end
    end

    always_comb begin
        w_eligible = '0;
        for (int t = 0; t < NUM_Threads; t++) begin
            w_eligible[t] = thread_ready[t] && !jump_en[t] && (r_blackout[t] == '0);
        end
    end

    rr_alloc u_rr_alloc (
        .i_eligible (w_eligible),
        .i_alu_free (~alu_busy),
        .i_rr_ptr   (r_rr),
        .o_assign   (w_assign),
        .o_rr_next  (w_rr_next)
    );

    always_comb begin
        w_grant = '0;
        for (int t = 0; t < NUM_Threads; t++) begin
            for (int a = 0; a < NUM_ALUs; a++) begin
                if (w_assign[a] == thread_id_t'(t)) w_grant[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp  <= {NUM_ALUs{THREAD_IDLE_ID}};
            r_grant <= '0;
            r_rr    <= '0;
        end else if (w_arb_en) begin
            r_disp  <= w_assign;
            r_grant <= w_grant;
            r_rr    <= w_rr_next;
        end else begin
            r_disp  <= {NUM_ALUs{THREAD_IDLE_ID}};
            r_grant <= '0;
        end
    end

    assign dispatch_threads = r_disp;
    assign grant_vec        = r_grant;
    assign rr_ptr           = r_rr;
endmodule

// File: tb/tb_thread_dispatcher.sv
// Directed bench for thread_dispatcher: stimulus queues hand-computed expectations,
// a monitor pops one per clock after the edge and compares.
`timescale 1ns/1ps
module tb_thread_dispatcher;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      thread_ready;
    logic [3:0]      jump_en;
    logic [3:0]      alu_busy;
    logic            freeze;
    logic [3:0][2:0] dispatch_threads;
    logic [3:0]      grant_vec;
    logic [2:0]      rr_ptr;

    typedef struct {
        logic [11:0] disp;
        logic [3:0]  grant;
        logic [2:0]  rr;
        int          id;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_id = 0;

    thread_dispatcher dut (
        .clk              (clk),
        .rst              (rst),
        .thread_ready     (thread_ready),
        .jump_en          (jump_en),
        .alu_busy         (alu_busy),
        .freeze           (freeze),
        .dispatch_threads (dispatch_threads),
        .grant_vec        (grant_vec),
        .rr_ptr           (rr_ptr)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] D(input int a0, input int a1, input int a2, input int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    localparam logic [11:0] IDLE = 12'h924;

    task automatic chk(input string nm, input int id, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    // Called at a negedge: apply inputs, queue the expected post-edge outputs, move to next negedge.
    task automatic drive(input logic [3:0] rdy, input logic [3:0] jmp, input logic [3:0] busy,
                         input logic frz, input logic [11:0] d, input logic [3:0] g, input logic [2:0] r);
        exp_t e;
        thread_ready = rdy;
        jump_en      = jmp;
        alu_busy     = busy;
        freeze       = frz;
        e.disp  = d;
        e.grant = g;
        e.rr    = r;
        e.id    = vec_id;
        vec_id++;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("disp",  e.id, dispatch_threads, e.disp);
                chk("grant", e.id, 12'(grant_vec),   12'(e.grant));
                chk("rr",    e.id, 12'(rr_ptr),      12'(e.rr));
            end
        end
    end

    initial begin
        thread_ready = '0;
        jump_en      = '0;
        alu_busy     = '0;
        freeze       = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_disp",  -1, dispatch_threads, IDLE);
        chk("rst_grant", -1, 12'(grant_vec),   12'h0);
        chk("rst_rr",    -1, 12'(rr_ptr),      12'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Startup window then full dispatch
        drive(4'hF, 4'h0, 4'h0, 1'b0, IDLE,         4'h0, 3'd0);
        drive(4'hF, 4'h0, 4'h0, 1'b0, IDLE,         4'h0, 3'd0);
        drive(4'hF, 4'h0, 4'h0, 1'b0, D(0,1,2,3),   4'hF, 3'd0);
        drive(4'hF, 4'h0, 4'h0, 1'b0, D(0,1,2,3),   4'hF, 3'd0);

        // Two free ALUs: alternate {0,1} / {2,3}
        drive(4'hF, 4'h0, 4'hC, 1'b0, D(0,1,4,4),   4'h3, 3'd2);
        drive(4'hF, 4'h0, 4'hC, 1'b0, D(2,3,4,4),   4'hC, 3'd0);
        drive(4'hF, 4'h0, 4'hC, 1'b0, D(0,1,4,4),   4'h3, 3'd2);
        drive(4'hF, 4'h0, 4'hC, 1'b0, D(2,3,4,4),   4'hC, 3'd0);

        // Jump on thread 1 with ALU3 busy: absent 3 cycles, then rotation resumes
        drive(4'hF, 4'h2, 4'h8, 1'b0, D(0,2,3,4),   4'hD, 3'd0);
        drive(4'hF, 4'h0, 4'h8, 1'b0, D(0,2,3,4),   4'hD, 3'd0);
        drive(4'hF, 4'h0, 4'h8, 1'b0, D(0,2,3,4),   4'hD, 3'd0);
        drive(4'hF, 4'h0, 4'h8, 1'b0, D(0,1,2,4),   4'h7, 3'd3);
        drive(4'hF, 4'h0, 4'h8, 1'b0, D(3,0,1,4),   4'hB, 3'd2);

        // Only thread 3 ready: wrap to 0
        drive(4'h8, 4'h0, 4'h0, 1'b0, D(3,4,4,4),   4'h8, 3'd0);
        drive(4'h8, 4'h0, 4'h0, 1'b0, D(3,4,4,4),   4'h8, 3'd0);

        // Freeze for 3 cycles with rr_ptr=2
        drive(4'hF, 4'h0, 4'hC, 1'b0, D(0,1,4,4),   4'h3, 3'd2);
        drive(4'hF, 4'h0, 4'hC, 1'b1, IDLE,         4'h0, 3'd2);
        drive(4'hF, 4'h0, 4'hC, 1'b1, IDLE,         4'h0, 3'd2);
        drive(4'hF, 4'h0, 4'hC, 1'b1, IDLE,         4'h0, 3'd2);
        drive(4'hF, 4'h0, 4'hC, 1'b0, D(2,3,4,4),   4'hC, 3'd0);

        // Non-contiguous free ALUs (1 and 3)
        drive(4'hF, 4'h0, 4'h5, 1'b0, D(4,0,4,1),   4'h3, 3'd2);

        // Asynchronous reset between edges while grants are active
        @(posedge clk);
        #2;
        chk("drain_pre_rst", -1, 12'(q.size()), 12'h0);
        rst = 1'b0;
        #1;
        chk("arst_disp",  -2, dispatch_threads, IDLE);
        chk("arst_grant", -2, 12'(grant_vec),   12'h0);
        chk("arst_rr",    -2, 12'(rr_ptr),      12'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(4'hF, 4'h0, 4'h0, 1'b0, IDLE,         4'h0, 3'd0);
        drive(4'hF, 4'h0, 4'h0, 1'b0, IDLE,         4'h0, 3'd0);
        drive(4'hF, 4'h0, 4'h0, 1'b0, D(0,1,2,3),   4'hF, 3'd0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("drain_end", -1, 12'(q.size()), 12'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
